mor1kx_wb32_slave_mem: RTL and testbench

Wishbone B3 32-bit slave (responder) fronting a single-port synchronous memory with 1-cycle read latency. It is the target-side counterpart of the CPU Wishbone bus bridges: on-chip RAM and boot-ROM wrappers sit behind it. It supports classic cycles and incrementing/wrapping read bursts with predictive prefetch, giving one ack per cycle when a burst address hits.

---
 rtl/mor1kx_wb32_slave_mem_pkg.sv | 25 ++
 rtl/mor1kx_wb32_slave_mem_burst_addr_next.sv | 28 ++
 rtl/mor1kx_wb32_slave_mem.sv | 141 ++++++++++++++
 tb/tb_mor1kx_wb32_slave_mem.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mor1kx_wb32_slave_mem_pkg.sv
// Shared Wishbone codes and FSM encodings for the 32-bit memory slave and
// its burst address helper.
package mor1kx_wb32_slave_mem_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SINGLE   = 2'd1,
    ST_RD_BURST = 2'd2
  } state_t;

  // Beat types that may continue a predicted read burst.
  function automatic logic cti_continues(input logic [2:0] cti);
    return (cti == CTI_INC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/mor1kx_wb32_slave_mem_burst_addr_next.sv
// Combinational Wishbone burst next-word-address generator (linear or
// wrap4/8/16); reusable by any slave that predicts burst addresses.
module mor1kx_wb_burst_addr_next #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            bte,
  output logic [ADDR_WIDTH-1:0] addr_next
);
  import mor1kx_wb32_slave_mem_pkg::*;

  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    addr_inc = addr + ADDR_WIDTH'(1);
    case (bte)
      BTE_WRAP4:  wrap_mask = ADDR_WIDTH'(3);
      BTE_WRAP8:  wrap_mask = ADDR_WIDTH'(7);
      BTE_WRAP16: wrap_mask = ADDR_WIDTH'(15);
      BTE_LINEAR: wrap_mask = '1;
      default:    wrap_mask = '1;
    endcase
    // Bits outside the wrap window are held; linear wraps at memory end.
    addr_next = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
  end

endmodule

// File: rtl/mor1kx_wb32_slave_mem.sv
// Wishbone B3 32-bit slave in front of a 1-cycle-latency synchronous memory,
// with predictive read bursts. Optional macro MOR1KX_WBS_ADDR_ERR_EN adds
// out-of-window error responses.
module mor1kx_wb32_slave_mem #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic [31:0]           mem_dat_o,
  input  logic [31:0]           mem_dat_i
);
  import mor1kx_wb32_slave_mem_pkg::*;

  state_t                state, state_nxt;
  logic                  ack_r, ack_nxt;
  logic                  err_r, err_nxt;
  logic                  rd_p1, rd_nxt;
  logic [ADDR_WIDTH-1:0] pred_adr_p1, pred_nxt;
  logic [ADDR_WIDTH-1:0] adr_word, adr_next;
  logic                  req, in_range, burst_hit;
  logic                  acc, hit, spec;
  logic                  unused_adr;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign adr_word = wbs_adr_i[ADDR_WIDTH+1:2];

`ifdef MOR1KX_WBS_ADDR_ERR_EN
  assign in_range   = (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign unused_adr = ^wbs_adr_i[1:0];
`else
  assign in_range   = 1'b1;
  assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};
`endif

  mor1kx_wb_burst_addr_next #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_next (
    .addr      (pred_adr_p1),
    .bte       (wbs_bte_i),
    .addr_next (adr_next)
  );

  // The beat the master shows now matches the word already being read.
  assign burst_hit = req & ~wbs_we_i & cti_continues(wbs_cti_i) &
                     in_range & (adr_word == pred_adr_p1);

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rd_nxt    = rd_p1;
    pred_nxt  = pred_adr_p1;
    acc       = 1'b0;
    hit       = 1'b0;
    spec      = 1'b0;
    case (state)
      ST_IDLE: acc = req & ~ack_r & ~(err_r & wbs_cyc_i);
      ST_SINGLE: state_nxt = ST_IDLE;
      ST_RD_BURST: begin
        if (ack_r) begin
          if (req && wbs_cti_i == CTI_INC) begin
            spec     = 1'b1;
            pred_nxt = adr_next;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (!req) begin
          state_nxt = ST_IDLE;
        end else if (burst_hit) begin
          hit = 1'b1;
          if (wbs_cti_i == CTI_INC) begin
            spec     = 1'b1;
            pred_nxt = adr_next;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          acc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (acc) begin
      rd_nxt = ~wbs_we_i;
      if (!in_range) begin
        err_nxt   = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        ack_nxt   = 1'b1;
        pred_nxt  = adr_word;
        state_nxt = (!wbs_we_i && wbs_cti_i == CTI_INC) ? ST_RD_BURST : ST_SINGLE;
      end
    end
  end

  // p0 -> p1: accept/prediction registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      ack_r <= 1'b0;
      err_r <= 1'b0;
      rd_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_r <= ack_nxt;
      err_r <= err_nxt;
      rd_p1 <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pred_adr_p1 <= pred_nxt;
  end

  assign mem_en_o  = rst & ((acc & in_range) | spec);
  assign mem_we_o  = (rst & acc & in_range & wbs_we_i) ? wbs_sel_i : 4'b0000;
  assign mem_adr_o = spec ? adr_next : adr_word;
  assign mem_dat_o = wbs_dat_i;

  assign wbs_ack_o = rst & wbs_cyc_i & (ack_r | hit);
  assign wbs_err_o = rst & wbs_cyc_i & err_r;
  assign wbs_rty_o = 1'b0;
  assign wbs_dat_o = (wbs_ack_o && ((ack_r && rd_p1) || hit)) ? mem_dat_i : 32'h0;

endmodule

// File: tb/tb_mor1kx_wb32_slave_mem.sv
// Directed bench for mor1kx_wb32_slave_mem with a behavioural 1-cycle memory.
module tb_mor1kx_wb32_slave_mem;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   adr, dat, dat_o, mem_dat_o;
  logic [3:0]    sel, mem_we;
  logic          we, cyc, stb, ack, err, rty, mem_en;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          loaded = 1'b0;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mor1kx_wb32_slave_mem #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel), .wbs_we_i(we),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_adr_o(mem_adr),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_rdata)
  );

  function automatic logic [31:0] preload(input int i);
    case (i)
      0:       return 32'h0000_C0DE;
      5:       return 32'hA5A5_0014;
      6:       return 32'hA5A5_0018;
      7:       return 32'hA5A5_001C;
      8:       return 32'h2020_0020;
      9:       return 32'h2020_0024;
      16:      return 32'h4040_0040;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= preload(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_adr][8*b +: 8] <= mem_dat_o[8*b +: 8];
      mem_rdata <= mem[mem_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [31:0] a, input logic w,
                       input logic [2:0] t, input logic [1:0] b);
    cyc = c; stb = c; adr = a; we = w; cti = t; bte = b;
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; dat = 32'h0; sel = 4'hF;
    drive(1'b1, 32'h10, 1'b1, 3'b000, 2'b00);
    repeat (2) @(posedge clk);
    smp;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rty", rty, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    nxt; rst = 1'b1; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("idle_ack", ack, 0);

    // classic write, sel 0011
    nxt; drive(1'b1, 32'h10, 1'b1, 3'b000, 2'b00); dat = 32'hDEAD_BEEF; sel = 4'b0011;
    smp; chk("wr_en", mem_en, 1); chk("wr_we", mem_we, 4'b0011);
    chk("wr_adr", mem_adr, 4); chk("wr_mdat", mem_dat_o, 32'hDEAD_BEEF); chk("wr_noack", ack, 0);
    nxt; smp; chk("wr_ack", ack, 1); chk("wr_ack_dat", dat_o, 0); chk("wr_ack_en", mem_en, 0);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00); sel = 4'hF;
    smp; chk("wr_done", ack, 0);

    // classic read back
    nxt; drive(1'b1, 32'h10, 1'b0, 3'b000, 2'b00);
    smp; chk("rd_en", mem_en, 1); chk("rd_we", mem_we, 0); chk("rd_noack", ack, 0);
    nxt; smp; chk("rd_ack", ack, 1); chk("rd_dat", dat_o, 32'h0000_BEEF);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("rd_once", ack, 0);

    // wrap4 read burst from 0x1C
    nxt; drive(1'b1, 32'h1C, 1'b0, 3'b010, 2'b01);
    smp; chk("w4_noack", ack, 0); chk("w4_adr0", mem_adr, 7);
    nxt; smp; chk("w4_ack0", ack, 1); chk("w4_dat0", dat_o, 32'hA5A5_001C); chk("w4_pred1", mem_adr, 4);
    nxt; drive(1'b1, 32'h10, 1'b0, 3'b010, 2'b01);
    smp; chk("w4_ack1", ack, 1); chk("w4_dat1", dat_o, 32'h0000_BEEF); chk("w4_pred2", mem_adr, 5);
    nxt; drive(1'b1, 32'h14, 1'b0, 3'b010, 2'b01);
    smp; chk("w4_ack2", ack, 1); chk("w4_dat2", dat_o, 32'hA5A5_0014); chk("w4_pred3", mem_adr, 6);
    nxt; drive(1'b1, 32'h18, 1'b0, 3'b111, 2'b01);
    smp; chk("w4_ack3", ack, 1); chk("w4_dat3", dat_o, 32'hA5A5_0018); chk("w4_eob_en", mem_en, 0);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("w4_done", ack, 0);

    // linear burst, jump to 0x40 at beat 2
    nxt; drive(1'b1, 32'h20, 1'b0, 3'b010, 2'b00);
    smp; chk("mp_noack", ack, 0);
    nxt; smp; chk("mp_ack0", ack, 1); chk("mp_dat0", dat_o, 32'h2020_0020); chk("mp_pred", mem_adr, 9);
    nxt; drive(1'b1, 32'h24, 1'b0, 3'b010, 2'b00);
    smp; chk("mp_ack1", ack, 1); chk("mp_dat1", dat_o, 32'h2020_0024);
    nxt; drive(1'b1, 32'h40, 1'b0, 3'b111, 2'b00);
    smp; chk("mp_bubble", ack, 0); chk("mp_en", mem_en, 1); chk("mp_adr", mem_adr, 16);
    nxt; smp; chk("mp_ack2", ack, 1); chk("mp_dat2", dat_o, 32'h4040_0040);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("mp_done", ack, 0);

    // master abort in first ack cycle
    nxt; drive(1'b1, 32'h14, 1'b0, 3'b010, 2'b00);
    smp; chk("ab_en", mem_en, 1);
    nxt; drive(1'b0, 32'h14, 1'b0, 3'b010, 2'b00);
    smp; chk("ab_noack", ack, 0); chk("ab_nospec", mem_en, 0);
    nxt; drive(1'b1, 32'h18, 1'b0, 3'b000, 2'b00);
    smp; chk("ab_rd_noack", ack, 0); chk("ab_rd_en", mem_en, 1); chk("ab_rd_adr", mem_adr, 6);
    nxt; smp; chk("ab_rd_ack", ack, 1); chk("ab_rd_dat", dat_o, 32'hA5A5_0018);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("ab_done", ack, 0);

    // reset pulse mid-burst
    nxt; drive(1'b1, 32'h10, 1'b0, 3'b010, 2'b00);
    nxt; smp; chk("rb_ack0", ack, 1);
    nxt; drive(1'b1, 32'h14, 1'b0, 3'b010, 2'b00); rst = 1'b0;
    smp; chk("rb_ack", ack, 0); chk("rb_err", err, 0); chk("rb_en", mem_en, 0);
    chk("rb_we", mem_we, 0); chk("rb_dat", dat_o, 0);
    nxt; rst = 1'b1; drive(1'b1, 32'h1C, 1'b0, 3'b000, 2'b00);
    smp; chk("rb_stale", ack, 0); chk("rb_new_en", mem_en, 1); chk("rb_new_adr", mem_adr, 7);
    nxt; smp; chk("rb_new_ack", ack, 1); chk("rb_new_dat", dat_o, 32'hA5A5_001C);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("rb_done", ack, 0);

    // read beyond the memory window
    nxt; drive(1'b1, 32'h1000, 1'b0, 3'b000, 2'b00);
`ifdef MOR1KX_WBS_ADDR_ERR_EN
    smp; chk("oor_en", mem_en, 0); chk("oor_noerr", err, 0);
    nxt; smp; chk("oor_err", err, 1); chk("oor_ack", ack, 0);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("oor_err_once", err, 0);
`else
    smp; chk("alias_en", mem_en, 1); chk("alias_adr", mem_adr, 0);
    nxt; smp; chk("alias_ack", ack, 1); chk("alias_dat", dat_o, 32'h0000_C0DE); chk("alias_err", err, 0);
    nxt; drive(1'b0, 32'h0, 1'b0, 3'b000, 2'b00);
    smp; chk("alias_done", ack, 0);
`endif

    if (passed + failed != total) $error("check bookkeeping inconsistent");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
